// File: rtl/wbuf.sv
// wbuf: posted-write FIFO that drains stores one at a time onto the write bus, with a line-granular hazard check
`ifndef CMEM_OFFS_LEN
`define CMEM_OFFS_LEN 6
`endif
`ifndef CMEM_BLK_LEN
`define CMEM_BLK_LEN (64-`CMEM_OFFS_LEN)
`endif
module wbuf #(
  parameter int WBUF_DEPTH = 4,
  parameter int WBUF_PTR   = $clog2(WBUF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              s_addr,
  input  logic [63:0]              s_wdata,
  input  logic [1:0]               s_len,
  input  logic                     s_wr,
  output logic                     s_stall,
  output logic [63:0]              b_addr_w,
  output logic [63:0]              b_wdata_w,
  output logic [1:0]               b_len_w,
  output logic                     b_wr_w,
  input  logic                     b_wr_done,
  input  logic [`CMEM_BLK_LEN-1:0] chk_addr,
  output logic                     chk_hit,
  output logic                     wbuf_empty
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  localparam logic [WBUF_PTR:0] FULL_CNT = (WBUF_PTR+1)'(WBUF_DEPTH);
  state_t              r_state, w_next;
  logic [63:0]         r_addr [WBUF_DEPTH];
  logic [63:0]         r_data [WBUF_DEPTH];
  logic [1:0]          r_len  [WBUF_DEPTH];
  logic [WBUF_PTR-1:0] r_head, r_tail;
  logic [WBUF_PTR:0]   r_count;
  logic                w_full, w_empty, w_push, w_pop, w_load;
  assign w_full     = r_count == FULL_CNT;
  assign w_empty    = r_count == '0;
  assign w_push     = s_wr && !w_full;
  assign s_stall    = s_wr && w_full;
  assign w_pop      = r_state == ISSUE && b_wr_done;
  assign b_wr_w     = r_state == ISSUE;
  assign wbuf_empty = w_empty && r_state == IDLE;
  // IDLE and GAP share the same exit rule: issue whenever anything is queued
  always_comb w_next = r_state == ISSUE ? (b_wr_done ? GAP : ISSUE) : (w_empty ? IDLE : ISSUE);
  assign w_load = r_state != ISSUE && w_next == ISSUE;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= s_addr;
      r_data[r_tail] <= s_wdata;
      r_len[r_tail]  <= s_len;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      b_addr_w  <= '0;
      b_wdata_w <= '0;
      b_len_w   <= '0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + (WBUF_PTR+1)'(w_push) - (WBUF_PTR+1)'(w_pop);
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_load) begin
        b_addr_w  <= r_addr[r_head];
        b_wdata_w <= r_data[r_head];
        b_len_w   <= r_len[r_head];
      end
    end
  end
  // slot i is valid when its distance from head is below the occupancy
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++)
      chk_hit = chk_hit | (({1'b0, WBUF_PTR'(i) - r_head} < r_count) && r_addr[i][63:`CMEM_OFFS_LEN] == chk_addr);
  end
endmodule

// File: tb/tb_wbuf.sv
// tb_wbuf: table vectors, directed corner sequences and randomized traffic against a queue-based reference model
module tb_wbuf;
  localparam int DEPTH = 4;
  typedef struct packed {logic [63:0] a; logic [63:0] d; logic [1:0] l;} ent_t;
  typedef struct {bit wr; logic [63:0] a; bit done; bit xs; bit xw; logic [63:0] xa; bit xe;} vec_t;
  logic        clk = 0, rst = 1;
  logic [63:0] s_addr = 0, s_wdata = 0, b_addr_w, b_wdata_w;
  logic [1:0]  s_len = 0, b_len_w;
  logic        s_wr = 0, s_stall, b_wr_w, b_wr_done = 0, chk_hit, wbuf_empty;
  logic [57:0] chk_addr = 0;
  always #5 clk = ~clk;
  wbuf dut (.clk(clk), .rst(rst), .s_addr(s_addr), .s_wdata(s_wdata), .s_len(s_len), .s_wr(s_wr),
    .s_stall(s_stall), .b_addr_w(b_addr_w), .b_wdata_w(b_wdata_w), .b_len_w(b_len_w), .b_wr_w(b_wr_w),
    .b_wr_done(b_wr_done), .chk_addr(chk_addr), .chk_hit(chk_hit), .wbuf_empty(wbuf_empty));
  ent_t pend[$], acc[$], wrq[$];
  bit   m_busy, m_gap;
  int   errs = 0, checks = 0;
  vec_t tbl[16];
  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time); end
  endtask
  task automatic chk64(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time); end
  endtask
  task automatic model_reset();
    pend.delete();
    m_busy = 0;
    m_gap  = 0;
  endtask
  task automatic drive(input bit wr, input logic [63:0] a, input logic [63:0] d, input logic [1:0] l, input bit done, input logic [57:0] ck);
    s_wr = wr; s_addr = a; s_wdata = d; s_len = l; b_wr_done = done; chk_addr = ck;
    #2;
  endtask
  task automatic model_check();
    bit hit = 0;
    ent_t e;
    foreach (pend[i]) if (pend[i].a[63:6] == chk_addr) hit = 1;
    chk1("s_stall", s_stall, s_wr && pend.size() == DEPTH);
    chk1("b_wr_w", b_wr_w, m_busy);
    if (m_busy) begin
      chk64("b_addr_w", b_addr_w, pend[0].a);
      chk64("b_wdata_w", b_wdata_w, pend[0].d);
      chk64("b_len_w", 64'(b_len_w), 64'(pend[0].l));
    end
    chk1("chk_hit", chk_hit, hit);
    chk1("wbuf_empty", wbuf_empty, pend.size() == 0 && !m_busy && !m_gap);
    if (b_wr_w && b_wr_done) begin e = '{b_addr_w, b_wdata_w, b_len_w}; wrq.push_back(e); end
  endtask
  task automatic tick();
    int   n = pend.size();
    ent_t e;
    @(posedge clk);
    if (m_busy && b_wr_done) void'(pend.pop_front());
    if (s_wr && n < DEPTH) begin e = '{s_addr, s_wdata, s_len}; pend.push_back(e); acc.push_back(e); end
    if (m_busy) begin m_gap = b_wr_done; m_busy = !b_wr_done; end
    else begin m_gap = 0; m_busy = n > 0; end
    #1;
  endtask
  task automatic cyc(input bit wr, input logic [63:0] a, input bit done, input logic [57:0] ck);
    drive(wr, a, {a[31:0], ~a[31:0]}, a[4:3], done, ck);
    model_check();
    tick();
  endtask
  initial begin
    tbl[0]  = '{1, 64'h100, 0, 0, 0, 64'h0,   1};
    tbl[1]  = '{1, 64'h108, 0, 0, 0, 64'h0,   0};
    tbl[2]  = '{1, 64'h110, 0, 0, 1, 64'h100, 0};
    tbl[3]  = '{1, 64'h118, 0, 0, 1, 64'h100, 0};
    tbl[4]  = '{1, 64'h120, 0, 1, 1, 64'h100, 0};
    tbl[5]  = '{1, 64'h120, 1, 1, 1, 64'h100, 0};
    tbl[6]  = '{1, 64'h120, 0, 0, 0, 64'h0,   0};
    tbl[7]  = '{0, 64'h0,   1, 0, 1, 64'h108, 0};
    tbl[8]  = '{0, 64'h0,   0, 0, 0, 64'h0,   0};
    tbl[9]  = '{0, 64'h0,   1, 0, 1, 64'h110, 0};
    tbl[10] = '{0, 64'h0,   1, 0, 0, 64'h0,   0};
    tbl[11] = '{0, 64'h0,   1, 0, 1, 64'h118, 0};
    tbl[12] = '{0, 64'h0,   0, 0, 0, 64'h0,   0};
    tbl[13] = '{0, 64'h0,   1, 0, 1, 64'h120, 0};
    tbl[14] = '{0, 64'h0,   0, 0, 0, 64'h0,   0};
    tbl[15] = '{0, 64'h0,   0, 0, 0, 64'h0,   1};
    model_reset();
    s_wr = 1;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset b_wr_w", b_wr_w, 0);
    chk64("reset b_addr_w", b_addr_w, 0);
    chk1("reset s_stall", s_stall, 0);
    chk1("reset wbuf_empty", wbuf_empty, 1);
    chk1("reset chk_hit", chk_hit, 0);
    s_wr = 0;
    rst = 0;
    // single store, two-cycle latency to the bus
    drive(1, 64'h8000_1008, 64'hDEAD_BEEF, 2'd2, 0, 58'd0); model_check(); tick();
    drive(0, 64'h0, 64'h0, 2'd0, 0, 58'd0); model_check(); tick();
    chk1("t1 b_wr_w", b_wr_w, 1);
    chk64("t1 b_addr_w", b_addr_w, 64'h8000_1008);
    chk64("t1 b_wdata_w", b_wdata_w, 64'hDEAD_BEEF);
    chk64("t1 b_len_w", 64'(b_len_w), 64'd2);
    cyc(0, 64'h0, 1, 58'd0);
    chk1("t1 gap b_wr_w", b_wr_w, 0);
    chk1("t1 gap wbuf_empty", wbuf_empty, 0);
    cyc(0, 64'h0, 0, 58'd0);
    chk1("t1 idle wbuf_empty", wbuf_empty, 1);
    // fill to full, stall, then drain in order
    foreach (tbl[k]) begin
      drive(tbl[k].wr, tbl[k].a, 64'(k), 2'd3, tbl[k].done, 58'd0);
      model_check();
      chk1("tbl s_stall", s_stall, tbl[k].xs);
      chk1("tbl b_wr_w", b_wr_w, tbl[k].xw);
      if (tbl[k].xw) chk64("tbl b_addr_w", b_addr_w, tbl[k].xa);
      chk1("tbl wbuf_empty", wbuf_empty, tbl[k].xe);
      tick();
    end
    // hazard check on line 0x8000_0040
    cyc(1, 64'h8000_0040, 0, 58'h200_0001);
    drive(0, 64'h0, 64'h0, 2'd0, 0, 58'h200_0002); chk1("t3 adjacent", chk_hit, 0); model_check(); tick();
    drive(0, 64'h0, 64'h0, 2'd0, 0, 58'h200_0001); chk1("t3 hit issue", chk_hit, 1); model_check(); tick();
    drive(0, 64'h0, 64'h0, 2'd0, 1, 58'h200_0001); chk1("t3 hit done", chk_hit, 1); model_check(); tick();
    drive(0, 64'h0, 64'h0, 2'd0, 0, 58'h200_0001); chk1("t3 after pop", chk_hit, 0); model_check(); tick();
    cyc(0, 64'h0, 0, 58'h200_0000);
    // enqueue and pop in the same cycle
    cyc(1, 64'h200, 0, 58'd0);
    cyc(0, 64'h0, 0, 58'd0);
    cyc(1, 64'h208, 1, 58'd0);
    cyc(0, 64'h0, 0, 58'd0);
    chk1("t4 issue B", b_wr_w, 1);
    chk64("t4 addr B", b_addr_w, 64'h208);
    cyc(0, 64'h0, 1, 58'd0);
    cyc(0, 64'h0, 0, 58'd0);
    chk1("t4 drained", wbuf_empty, 1);
    // asynchronous reset mid-ISSUE with three entries queued
    cyc(1, 64'h300, 0, 58'hC);
    cyc(1, 64'h308, 0, 58'hC);
    cyc(1, 64'h310, 0, 58'hC);
    drive(0, 64'h0, 64'h0, 2'd0, 0, 58'hC);
    chk1("t5 pre b_wr_w", b_wr_w, 1);
    chk1("t5 pre chk_hit", chk_hit, 1);
    rst = 1;
    #1;
    chk1("t5 async b_wr_w", b_wr_w, 0);
    chk1("t5 async wbuf_empty", wbuf_empty, 1);
    chk1("t5 async chk_hit", chk_hit, 0);
    model_reset();
    b_wr_done = 1;
    @(posedge clk);
    #1;
    chk1("t5 in-reset b_wr_w", b_wr_w, 0);
    rst = 0;
    repeat (3) cyc(0, 64'h0, 1, 58'hC);
    // randomized traffic
    acc.delete();
    wrq.delete();
    for (int c = 0; c < 200; c++)
      cyc(1'($urandom_range(0, 1)), 64'h8000_0000 + 64'($urandom_range(0, 3)) * 64 + 64'($urandom_range(0, 7)) * 8,
          $urandom_range(0, 99) < 30, 58'(64'h8000_0000 >> 6) + 58'($urandom_range(0, 4)));
    for (int c = 0; c < 60 && (pend.size() != 0 || m_busy || m_gap); c++) cyc(0, 64'h0, 1, 58'd0);
    chk64("drain bound", 64'(pend.size()), 64'd0);
    chk64("write count", 64'(wrq.size()), 64'(acc.size()));
    for (int i = 0; i < wrq.size() && i < acc.size(); i++) begin
      chk64("seq addr", wrq[i].a, acc[i].a);
      chk64("seq data", wrq[i].d, acc[i].d);
      chk64("seq len", 64'(wrq[i].l), 64'(acc[i].l));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
